arbiter_hold: RTL and testbench

Parametrised request/grant arbiter and successor to the fixed-priority `arbiter`. It selects between fixed-priority and round-robin policy with a parameter. A granted requester keeps the grant for as long as its request stays asserted. An optional hold limit forces re-arbitration when other requesters are waiting. It sits between `WIDTH` masters and one shared resource, and it drives the same `grt`/`id`/`pre_grt`/`pre_id` view the existing stimulus and check benches consume.

---
 rtl/arbiter_hold.sv | 60 ++++++
 tb/tb_arbiter_hold.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/arbiter_hold.sv
// arbiter_hold: fixed-priority or round-robin arbiter with grant hold and optional hold limit
module arbiter_hold #(
  parameter int WIDTH = 32,
  parameter int MODE = 0,
  parameter int MAX_HOLD = 0,
  localparam int BITW = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] req,
  output logic [WIDTH-1:0] grt,
  output logic [BITW:0]    id,
  output logic [WIDTH-1:0] pre_grt,
  output logic [BITW:0]    pre_id
);
  localparam int HW = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
  logic [WIDTH-1:0] grt_q, grt_d, cand;
  logic [BITW:0] id_q, id_d;
  logic [BITW-1:0] ptr_q, ptr_d, g, pick;
  logic keep, found, others, expired;
  int k;
  assign g = id_q[BITW-1:0];
  assign others = |(req & ~grt_q);
  generate
    if (MAX_HOLD > 0) begin : g_hold
      logic [HW-1:0] hcnt_q, hcnt_d;
      assign expired = (hcnt_q == HW'(MAX_HOLD)) && others;
      always_comb hcnt_d = keep ? hcnt_q + HW'(hcnt_q != HW'(MAX_HOLD)) : HW'(found);
      always_ff @(posedge clk) hcnt_q <= rst ? '0 : hcnt_d;
    end else begin : g_nohold
      assign expired = 1'b0;
    end
  endgenerate
  always_comb begin
    keep = id_q[BITW] && req[g] && !expired;
    cand = expired ? req & ~grt_q : req;
    found = 1'b0;
    pick = '0;
    k = 0;
    for (int i = 0; i < WIDTH; i++) begin
      k = (MODE == 1) ? (int'(ptr_q) + i) % WIDTH : i;
      if (!found && cand[k]) begin
        found = 1'b1;
        pick = BITW'(k);
      end
    end
    grt_d = keep ? grt_q : (found ? WIDTH'(1) << pick : '0);
    id_d = keep ? id_q : (found ? {1'b1, pick} : '0);
    ptr_d = (MODE == 1 && !keep && found) ? BITW'((int'(pick) + 1) % WIDTH) : ptr_q;
  end
  always_ff @(posedge clk) begin
    grt_q <= rst ? '0 : grt_d;
    id_q <= rst ? '0 : id_d;
    ptr_q <= rst ? '0 : ptr_d;
  end
  assign grt = grt_q;
  assign id = id_q;
  assign pre_grt = rst ? '0 : grt_d;
  assign pre_id = rst ? '0 : id_d;
endmodule

// File: tb/tb_arbiter_hold.sv
// tb_arbiter_hold: five arbiter configurations checked every cycle against an owner/count/pointer model
module tb_arbiter_hold;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [3:0] req = 4'd0;
  int checks = 0;
  int errors = 0;
  bit armed = 1'b0;
  int owner[5] = '{-1, -1, -1, -1, -1};
  int cnt[5] = '{0, 0, 0, 0, 0};
  int ptr[5] = '{0, 0, 0, 0, 0};
  int wd[5] = '{4, 4, 4, 4, 1};
  int md[5] = '{0, 1, 0, 1, 0};
  int mh[5] = '{0, 2, 3, 0, 0};
  int bw[5] = '{2, 2, 2, 2, 1};
  int seq_rr[9] = '{1, 1, 2, 2, 4, 4, 8, 8, 1};
  int seq_fx[9] = '{1, 1, 1, 2, 2, 2, 1, 1, 1};
  logic [31:0] go[5], po[5], io[5], pio[5];
  int no, nc, np, mo, mc, mp;
  logic [3:0] r;

  always #5 clk = ~clk;

  for (genvar j = 0; j < 4; j++) begin : g_dut
    logic [3:0] gr, pg;
    logic [2:0] ii, pi;
    arbiter_hold #(.WIDTH(4), .MODE(j % 2), .MAX_HOLD(j == 1 ? 2 : (j == 2 ? 3 : 0))) u (
      .clk(clk), .rst(rst), .req(req), .grt(gr), .id(ii), .pre_grt(pg), .pre_id(pi));
    assign go[j] = {28'd0, gr};
    assign po[j] = {28'd0, pg};
    assign io[j] = {29'd0, ii};
    assign pio[j] = {29'd0, pi};
  end

  logic gr1, pg1;
  logic [1:0] ii1, pi1;
  arbiter_hold #(.WIDTH(1), .MODE(0), .MAX_HOLD(0)) u_w1 (
    .clk(clk), .rst(rst), .req(req[0]), .grt(gr1), .id(ii1), .pre_grt(pg1), .pre_id(pi1));
  assign go[4] = {31'd0, gr1};
  assign po[4] = {31'd0, pg1};
  assign io[4] = {30'd0, ii1};
  assign pio[4] = {30'd0, pi1};

  function automatic logic [31:0] eg(input int o);
    return (o < 0) ? 32'd0 : 32'd1 << o;
  endfunction

  function automatic logic [31:0] eid(input int o, input int b);
    return (o < 0) ? 32'd0 : ((32'd1 << b) | 32'(o));
  endfunction

  task automatic predict(input int k, output int o, output int c, output int p);
    bit oth, ex;
    int j;
    oth = 1'b0;
    for (int x = 0; x < wd[k]; x++) if (req[x] && x != owner[k]) oth = 1'b1;
    ex = mh[k] > 0 && cnt[k] >= mh[k] && oth;
    o = -1;
    c = 0;
    p = ptr[k];
    if (rst) p = 0;
    else if (owner[k] >= 0 && req[owner[k]] && !ex) begin
      o = owner[k];
      c = (mh[k] > 0) ? ((cnt[k] < mh[k]) ? cnt[k] + 1 : mh[k]) : 0;
    end else begin
      for (int off = 0; off < wd[k]; off++) begin
        j = md[k] ? (ptr[k] + off) % wd[k] : off;
        if (o < 0 && req[j] && !(ex && j == owner[k])) o = j;
      end
      if (o >= 0) begin
        c = (mh[k] > 0) ? 1 : 0;
        if (md[k] != 0) p = (o + 1) % wd[k];
      end
    end
  endtask

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h at %0t", nm, got, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    for (int k = 0; k < 5; k++) begin
      predict(k, mo, mc, mp);
      owner[k] <= mo;
      cnt[k] <= mc;
      ptr[k] <= mp;
    end
    if (rst) armed <= 1'b1;
  end

  always @(negedge clk) begin
    if (armed) begin
      for (int k = 0; k < 5; k++) begin
        predict(k, no, nc, np);
        chk($sformatf("grt[%0d]", k), go[k], eg(owner[k]));
        chk($sformatf("id[%0d]", k), io[k], eid(owner[k], bw[k]));
        chk($sformatf("pre_grt[%0d]", k), po[k], eg(no));
        chk($sformatf("pre_id[%0d]", k), pio[k], eid(no, bw[k]));
      end
    end
  end

  task automatic cyc(input logic [3:0] rv, input logic rs);
    req = rv;
    rst = rs;
    @(posedge clk);
    #1;
  endtask

  initial begin
    repeat (3) cyc(4'hF, 1'b1);
    chk("reset_grt", go[0], 32'd0);
    chk("reset_id", io[0], 32'd0);
    chk("reset_pre_grt", po[0], 32'd0);
    cyc(4'hF, 1'b0);
    chk("post_reset_grt", go[0], 32'b0001);
    cyc(4'b1010, 1'b0);
    chk("fp_grt", go[0], 32'b0010);
    chk("fp_id", io[0], 32'b101);
    chk("w1_idle", go[4], 32'd0);
    cyc(4'b1011, 1'b0);
    chk("fp_hold", go[0], 32'b0010);
    chk("w1_grt", go[4], 32'd1);
    chk("w1_id", io[4], 32'b10);
    cyc(4'b1001, 1'b0);
    chk("fp_release", go[0], 32'b0001);
    cyc(4'h0, 1'b1);
    for (int i = 0; i < 9; i++) begin
      cyc(4'hF, 1'b0);
      chk($sformatf("rr_seq%0d", i), go[1], 32'(seq_rr[i]));
    end
    cyc(4'h0, 1'b1);
    for (int i = 0; i < 10; i++) begin
      cyc(4'b0100, 1'b0);
      chk($sformatf("lone%0d", i), go[1], 32'b0100);
    end
    cyc(4'h0, 1'b0);
    chk("lone_drop_grt", go[1], 32'd0);
    chk("lone_drop_id", io[1], 32'd0);
    cyc(4'h0, 1'b1);
    for (int i = 0; i < 9; i++) begin
      cyc(4'b0011, 1'b0);
      chk($sformatf("fx_seq%0d", i), go[2], 32'(seq_fx[i]));
    end
    cyc(4'h0, 1'b0);
    cyc(4'b1000, 1'b0);
    chk("mid_pre", go[1], 32'b1000);
    cyc(4'b1001, 1'b1);
    chk("mid_rst", go[1], 32'd0);
    cyc(4'b1001, 1'b0);
    chk("mid_after", go[1], 32'b0001);
    for (int i = 0; i < 400; i++) begin
      r = 4'($urandom);
      cyc(r | 4'($urandom), $urandom_range(0, 40) == 0);
    end
    cyc(4'h0, 1'b0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
